usb_devtrsac_mep: RTL

Parametrised multi-endpoint successor to `usb_devtrsac`. It sits between the USB packet decoder/encoder and the endpoint buffers and runs the device-side transaction protocol for IN, OUT and SETUP across `EP_NUM` endpoints. Protocol handling covers token filtering, per-endpoint/per-direction data toggles, ACK/NAK/STALL selection and a host-response timeout. Endpoint buffers see only one-cycle commit/discard strobes and never handle protocol state.

---
 rtl/usb_devtrsac_mep.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/usb_devtrsac_mep.sv
// usb_devtrsac_mep: device-side USB transaction engine (IN/OUT/SETUP) across EP_NUM endpoints.
// Owns per-endpoint data toggles; buffers only see one-cycle commit/discard/rewind strobes.
module usb_devtrsac_mep #(
  parameter int EP_NUM = 4,
  parameter int TOUT   = 72
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        dev_addr,
  input  logic              rx_tok_valid,
  input  logic [3:0]        rx_tok_pid,
  input  logic [6:0]        rx_tok_addr,
  input  logic [3:0]        rx_tok_ep,
  input  logic              rx_data_valid,
  input  logic [3:0]        rx_data_pid,
  input  logic              rx_data_ok,
  input  logic              rx_hs_valid,
  input  logic [3:0]        rx_hs_pid,
  output logic              tx_req,
  output logic [3:0]        tx_pid,
  input  logic              tx_ack,
  input  logic              tx_done,
  input  logic [EP_NUM-1:0] ep_in_rdy,
  input  logic [EP_NUM-1:0] ep_out_rdy,
  input  logic [EP_NUM-1:0] ep_stall,
  input  logic [EP_NUM-1:0] tgl_clr,
  output logic [3:0]        ep_sel,
  output logic              ep_setup,
  output logic              ep_in_commit,
  output logic              ep_in_rewind,
  output logic              ep_out_commit,
  output logic              ep_out_discard
);
  localparam int TW = $clog2(TOUT + 1);
  localparam logic [3:0] PID_OUT = 4'b0001, PID_IN = 4'b1001, PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_D0 = 4'b0011, PID_D1 = 4'b1011;
  localparam logic [3:0] PID_ACK = 4'b0010, PID_NAK = 4'b1010, PID_STALL = 4'b1110;

  typedef enum logic [2:0] {IDLE, OUT_DATA, OUT_HS, IN_DATA, IN_HS, HS_ONLY} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [EP_NUM-1:0] tgl_in_q, tgl_in_d, tgl_out_q, tgl_out_d, sel_m;
  logic [3:0]        tx_pid_q, tx_pid_d, ep_sel_q, ep_sel_d;
  logic              tx_req_q, tx_req_d, ep_setup_q, ep_setup_d;
  logic              in_commit_q, in_commit_d, in_rewind_q, in_rewind_d;
  logic              out_commit_q, out_commit_d, out_discard_q, out_discard_d;
  logic [15:0]       in_rdy_x, out_rdy_x, stall_x, tgl_in_x, tgl_out_x;
  logic              tok_ok, tmo, good;

  // Zero-extended copies so a 4-bit endpoint number can index any EP_NUM.
  assign in_rdy_x  = 16'(ep_in_rdy);
  assign out_rdy_x = 16'(ep_out_rdy);
  assign stall_x   = 16'(ep_stall);
  assign tgl_in_x  = 16'(tgl_in_q);
  assign tgl_out_x = 16'(tgl_out_q);
  assign sel_m     = EP_NUM'(1) << ep_sel_q;
  assign tmo       = tmr_q == TW'(TOUT);
  assign tok_ok    = rx_tok_valid && rx_tok_addr == dev_addr && {1'b0, rx_tok_ep} < 5'(EP_NUM)
                     && (rx_tok_pid inside {PID_OUT, PID_IN, PID_SETUP});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      tgl_in_q      <= '0;
      tgl_out_q     <= '0;
      tx_req_q      <= 1'b0;
      tx_pid_q      <= '0;
      ep_sel_q      <= '0;
      ep_setup_q    <= 1'b0;
      in_commit_q   <= 1'b0;
      in_rewind_q   <= 1'b0;
      out_commit_q  <= 1'b0;
      out_discard_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      tgl_in_q      <= tgl_in_d;
      tgl_out_q     <= tgl_out_d;
      tx_req_q      <= tx_req_d;
      tx_pid_q      <= tx_pid_d;
      ep_sel_q      <= ep_sel_d;
      ep_setup_q    <= ep_setup_d;
      in_commit_q   <= in_commit_d;
      in_rewind_q   <= in_rewind_d;
      out_commit_q  <= out_commit_d;
      out_discard_q <= out_discard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (tok_ok) state_d = rx_tok_pid != PID_IN ? OUT_DATA
                                    : (stall_x[rx_tok_ep] || !in_rdy_x[rx_tok_ep]) ? HS_ONLY : IN_DATA;
      OUT_DATA: if (rx_data_valid) state_d = rx_data_ok ? OUT_HS : IDLE;
                else if (tmo) state_d = IDLE;
      IN_DATA:  if (tx_done) state_d = IN_HS;
      IN_HS:    if (rx_hs_valid || tmo) state_d = IDLE;
      default:  if (tx_done) state_d = IDLE;
    endcase
    // Saturates at TOUT; only meaningful while waiting for the host.
    tmr_d = state_d != state_q ? '0 : tmo ? tmr_q : tmr_q + 1'b1;
  end

  always_comb begin
    tx_req_d      = tx_req_q && !tx_ack;
    tx_pid_d      = tx_pid_q;
    ep_sel_d      = ep_sel_q;
    ep_setup_d    = ep_setup_q;
    in_commit_d   = 1'b0;
    in_rewind_d   = 1'b0;
    out_commit_d  = 1'b0;
    out_discard_d = 1'b0;
    tgl_in_d      = tgl_in_q;
    tgl_out_d     = tgl_out_q;
    good          = 1'b0;
    case (state_q)
      IDLE: if (tok_ok) begin
        ep_sel_d   = rx_tok_ep;
        ep_setup_d = rx_tok_pid == PID_SETUP;
        if (rx_tok_pid == PID_IN) begin
          tx_req_d = 1'b1;
          tx_pid_d = stall_x[rx_tok_ep] ? PID_STALL : !in_rdy_x[rx_tok_ep] ? PID_NAK
                   : tgl_in_x[rx_tok_ep] ? PID_D1 : PID_D0;
        end
      end
      OUT_DATA: begin
        // SETUP bypasses halt and buffer-space checks and only accepts DATA0.
        good = rx_data_ok && (ep_setup_q ? rx_data_pid == PID_D0
             : !stall_x[ep_sel_q] && out_rdy_x[ep_sel_q] && rx_data_pid == (tgl_out_x[ep_sel_q] ? PID_D1 : PID_D0));
        if (rx_data_valid) begin
          tx_req_d      = rx_data_ok;
          tx_pid_d      = !rx_data_ok ? tx_pid_q : ep_setup_q ? PID_ACK
                        : stall_x[ep_sel_q] ? PID_STALL : !out_rdy_x[ep_sel_q] ? PID_NAK : PID_ACK;
          out_commit_d  = good;
          out_discard_d = !good;
          tgl_out_d     = !good ? tgl_out_q : ep_setup_q ? tgl_out_q | sel_m : tgl_out_q ^ sel_m;
          tgl_in_d      = good && ep_setup_q ? tgl_in_q | sel_m : tgl_in_q;
        end else out_discard_d = tmo;
      end
      IN_HS: begin
        in_commit_d = rx_hs_valid && rx_hs_pid == PID_ACK;
        in_rewind_d = rx_hs_valid ? rx_hs_pid != PID_ACK : tmo;
        tgl_in_d    = in_commit_d ? tgl_in_q ^ sel_m : tgl_in_q;
      end
      default: ;
    endcase
    tgl_in_d  = tgl_in_d & ~tgl_clr;
    tgl_out_d = tgl_out_d & ~tgl_clr;
  end

  assign tx_req         = tx_req_q;
  assign tx_pid         = tx_pid_q;
  assign ep_sel         = ep_sel_q;
  assign ep_setup       = ep_setup_q;
  assign ep_in_commit   = in_commit_q;
  assign ep_in_rewind   = in_rewind_q;
  assign ep_out_commit  = out_commit_q;
  assign ep_out_discard = out_discard_q;
endmodule
